// File: rtl/axis_eth_fcs_insert_ctrl_if.sv
// Byte-wide AXI4-Stream link used on both sides of the FCS inserter.
//   tdata  : frame byte
//   tvalid : beat valid (master -> slave)
//   tready : beat ready (slave -> master)
//   tlast  : last beat of the frame
//   tuser  : frame error flag
interface axis_eth_fcs_insert_ctrl_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_eth_fcs_insert_ctrl.sv
// Ethernet TX FCS inserter: passes payload bytes through with zero latency,
// zero-pads short frames to MIN_FRAME_LENGTH-4 bytes, then appends the
// CRC-32 FCS least significant byte first.
//   clk, rst : clock, asynchronous active-high reset
//   s_axis   : frame source (no FCS), tuser sampled on the tlast beat
//   m_axis   : payload / pad / FCS output, tlast+tuser on the last FCS byte
//   busy     : frame in flight (first accepted byte until last FCS accepted)
module axis_eth_fcs_insert_ctrl #(
  parameter bit          ENABLE_PADDING   = 1'b1,
  parameter int unsigned MIN_FRAME_LENGTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  axis_eth_fcs_insert_ctrl_if.slave         s_axis,
  axis_eth_fcs_insert_ctrl_if.master        m_axis,
  output logic                              busy
);

  localparam int unsigned PtrW     = 16;
  localparam int unsigned CrcW     = 32;
  localparam int unsigned MinData  = MIN_FRAME_LENGTH - 4;
  localparam logic [CrcW-1:0] CrcInit = 32'hFFFF_FFFF;
  // Bit-reversed form of 0x04C11DB7 for the LSB-first (reflected) Galois LFSR.
  localparam logic [CrcW-1:0] PolyRev = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    ST_PAYLOAD = 2'd0,
    ST_PAD     = 2'd1,
    ST_FCS     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CrcW-1:0]   crc_q, crc_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [1:0]        fcs_cnt_q, fcs_cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [CrcW-1:0]   fcs;
  logic [7:0]        fcs_byte;
  logic              m_hs;
  logic [31:0]       ptr_inc;

  // One byte through the reflected CRC-32 LFSR, data LSB first.
  function automatic logic [CrcW-1:0] crc_step(input logic [CrcW-1:0] crc,
                                               input logic [7:0]      data);
    logic [CrcW-1:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ PolyRev;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign fcs     = ~crc_q;
  assign ptr_inc = 32'(ptr_q) + 32'd1;
  assign m_hs    = m_axis.tvalid & m_axis.tready;
  assign busy    = busy_q;

  // FCS byte mux, least significant byte first.
  always_comb begin
    fcs_byte = fcs[7:0];
    case (fcs_cnt_q)
      2'd0: fcs_byte = fcs[7:0];
      2'd1: fcs_byte = fcs[15:8];
      2'd2: fcs_byte = fcs[23:16];
      2'd3: fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

  // Output/handshake mux; reset forces both sides idle immediately.
  always_comb begin
    m_axis.tdata  = 8'h00;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tuser  = 1'b0;
    s_axis.tready = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_PAYLOAD: begin
          m_axis.tdata  = s_axis.tdata;
          m_axis.tvalid = s_axis.tvalid;
          s_axis.tready = m_axis.tready;
        end
        ST_PAD: begin
          m_axis.tvalid = 1'b1;
        end
        ST_FCS: begin
          m_axis.tvalid = 1'b1;
          m_axis.tdata  = fcs_byte;
          if (fcs_cnt_q == 2'd3) begin
            m_axis.tlast = 1'b1;
            m_axis.tuser = err_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state: everything advances only on an output handshake.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    ptr_d     = ptr_q;
    fcs_cnt_d = fcs_cnt_q;
    err_d     = err_q;
    busy_d    = busy_q;
    case (state_q)
      ST_PAYLOAD: begin
        if (m_hs) begin
          crc_d  = crc_step(crc_q, s_axis.tdata);
          ptr_d  = (ptr_q == 16'hFFFF) ? ptr_q : ptr_q + 16'd1;
          busy_d = 1'b1;
          if (s_axis.tlast) begin
            err_d = s_axis.tuser;
            // ptr_inc is the byte count including this last byte.
            if (ENABLE_PADDING && (ptr_inc < MinData)) state_d = ST_PAD;
            else                                       state_d = ST_FCS;
          end
        end
      end
      ST_PAD: begin
        if (m_hs) begin
          crc_d = crc_step(crc_q, 8'h00);
          ptr_d = ptr_q + 16'd1;
          if (ptr_inc == MinData) state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        if (m_hs) begin
          fcs_cnt_d = fcs_cnt_q + 2'd1;
          if (fcs_cnt_q == 2'd3) begin
            state_d   = ST_PAYLOAD;
            crc_d     = CrcInit;
            ptr_d     = '0;
            fcs_cnt_d = 2'd0;
            err_d     = 1'b0;
            busy_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_PAYLOAD;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PAYLOAD;
      crc_q     <= CrcInit;
      ptr_q     <= '0;
      fcs_cnt_q <= 2'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      ptr_q     <= ptr_d;
      fcs_cnt_q <= fcs_cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_axis_eth_fcs_insert_ctrl.sv
// Bench for the FCS inserter: one unpadded and one padded (64) instance,
// a frame-level model (payload + zero pad + CRC-32 FCS) checked every cycle,
// and literal expectations for the well-known "123456789" vectors.
`timescale 1ns/1ps
module tb_axis_eth_fcs_insert_ctrl;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       payload;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tuser = 1'b0;
  logic       m_tready = 1'b1;
  logic       rand_ready = 1'b0;

  logic [7:0] mo_tdata;
  logic       mo_tvalid, mo_tlast, mo_tuser, si_tready, mo_busy;
  logic       busy_np, busy_p;

  axis_eth_fcs_insert_ctrl_if s_np ();
  axis_eth_fcs_insert_ctrl_if m_np ();
  axis_eth_fcs_insert_ctrl_if s_p ();
  axis_eth_fcs_insert_ctrl_if m_p ();

  axis_eth_fcs_insert_ctrl #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64)) dut_np (
    .clk(clk), .rst(rst), .s_axis(s_np), .m_axis(m_np), .busy(busy_np));
  axis_eth_fcs_insert_ctrl #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64)) dut_p (
    .clk(clk), .rst(rst), .s_axis(s_p), .m_axis(m_p), .busy(busy_p));

  // Route the single stimulus port to the selected instance.
  assign s_np.tdata  = s_tdata;
  assign s_np.tvalid = s_tvalid & ~sel;
  assign s_np.tlast  = s_tlast;
  assign s_np.tuser  = s_tuser;
  assign m_np.tready = m_tready & ~sel;
  assign s_p.tdata   = s_tdata;
  assign s_p.tvalid  = s_tvalid & sel;
  assign s_p.tlast   = s_tlast;
  assign s_p.tuser   = s_tuser;
  assign m_p.tready  = m_tready & sel;

  assign mo_tdata  = sel ? m_p.tdata  : m_np.tdata;
  assign mo_tvalid = sel ? m_p.tvalid : m_np.tvalid;
  assign mo_tlast  = sel ? m_p.tlast  : m_np.tlast;
  assign mo_tuser  = sel ? m_p.tuser  : m_np.tuser;
  assign si_tready = sel ? s_p.tready : s_np.tready;
  assign mo_busy   = sel ? busy_p     : busy_np;

  int checks = 0;
  int passes = 0;

  beat_t exp_q[$];
  beat_t cap_q[$];
  logic  exp_busy = 1'b0;
  logic [31:0] crc_tab [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Standard table-driven reflected CRC-32; returns the FCS value.
  function automatic logic [31:0] crc32(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = (c >> 8) ^ crc_tab[8'(c[7:0] ^ b[i])];
    return ~c;
  endfunction

  // Expected output frame: payload, zero pad to 60 bytes, FCS LSB first.
  task automatic push_frame(input byte_q_t fr, input logic err, input logic pad);
    byte_q_t all;
    logic [31:0] f;
    beat_t bt;
    all = fr;
    foreach (fr[i]) begin
      bt = '{data: fr[i], last: 1'b0, user: 1'b0, payload: 1'b1};
      exp_q.push_back(bt);
    end
    while (pad && all.size() < 60) begin
      all.push_back(8'h00);
      bt = '{data: 8'h00, last: 1'b0, user: 1'b0, payload: 1'b0};
      exp_q.push_back(bt);
    end
    f = crc32(all);
    for (int k = 0; k < 4; k++) begin
      bt = '{data: f[8*k +: 8], last: (k == 3), user: (k == 3) ? err : 1'b0, payload: 1'b0};
      exp_q.push_back(bt);
    end
  endtask

  // Source driver; called and returns at posedge+1.
  task automatic send_frame(input byte_q_t fr, input logic err, input int gap_pct);
    int n;
    push_frame(fr, err, sel);
    for (int i = 0; i < fr.size(); i++) begin
      while (32'($urandom_range(0, 99)) < 32'(gap_pct)) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tdata  = fr[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == fr.size() - 1);
      s_tuser  = s_tlast ? err : 1'($urandom_range(0, 1));
      n = 0;
      forever begin
        @(negedge clk);
        if (si_tready) break;
        n++;
        if (n > 2000) begin
          $display("FAIL send_timeout: got no s_tready, expected handshake");
          checks++;
          finish_run();
        end
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        $display("FAIL drain_timeout: got %0d beats left, expected 0", exp_q.size());
        checks++;
        finish_run();
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic byte_q_t str_bytes(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Random sink readiness when enabled.
  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Per-cycle compare against the frame model.
  beat_t f_cur, a_cur;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_tvalid", 32'(mo_tvalid), 32'd0);
      check("rst_tready", 32'(si_tready), 32'd0);
      check("rst_busy", 32'(mo_busy), 32'd0);
      exp_q.delete();
      exp_busy = 1'b0;
    end else begin
      check("busy", 32'(mo_busy), 32'(exp_busy));
      if (exp_q.size() == 0) begin
        check("idle_tvalid", 32'(mo_tvalid), 32'd0);
      end else begin
        f_cur = exp_q[0];
        if (f_cur.payload) begin
          check("pt_tvalid", 32'(mo_tvalid), 32'(s_tvalid));
          check("pt_tready", 32'(si_tready), 32'(m_tready));
        end else begin
          check("pf_tvalid", 32'(mo_tvalid), 32'd1);
          check("pf_tready", 32'(si_tready), 32'd0);
        end
        if (mo_tvalid) begin
          check("tdata", 32'(mo_tdata), 32'(f_cur.data));
          check("tlast", 32'(mo_tlast), 32'(f_cur.last));
          check("tuser", 32'(mo_tuser), 32'(f_cur.user));
          if (m_tready) begin
            a_cur = '{data: mo_tdata, last: mo_tlast, user: mo_tuser, payload: f_cur.payload};
            cap_q.push_back(a_cur);
            void'(exp_q.pop_front());
            exp_busy = !f_cur.last;
          end
        end
      end
    end
  end

  initial begin
    byte_q_t fr;
    int zeros;
    logic [31:0] c;

    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[n] = c;
    end
    check("model_crc_pin", crc32(str_bytes("123456789")), 32'h26_39_F4_CB ^ 32'h26_39_F4_CB ^ 32'hCBF4_3926);

    // Reset: outputs idle even with the sink ready.
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", 32'(mo_tvalid), 32'd0);
    check("reset_tready", 32'(si_tready), 32'd0);
    check("reset_busy", 32'(mo_busy), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Padding off, "123456789".
    sel = 1'b0;
    cap_q.delete();
    send_frame(str_bytes("123456789"), 1'b0, 0);
    drain();
    check("np_len", 32'(cap_q.size()), 32'd13);
    if (cap_q.size() == 13) begin
      check("np_fcs0", 32'(cap_q[9].data), 32'h26);
      check("np_fcs1", 32'(cap_q[10].data), 32'h39);
      check("np_fcs2", 32'(cap_q[11].data), 32'hF4);
      check("np_fcs3", 32'(cap_q[12].data), 32'hCB);
      check("np_last", 32'(cap_q[12].last), 32'd1);
      check("np_last_early", 32'(cap_q[11].last), 32'd0);
      check("np_user", 32'(cap_q[12].user), 32'd0);
    end

    // Padding on, same payload: 51 zero bytes then FCS.
    sel = 1'b1;
    cap_q.delete();
    send_frame(str_bytes("123456789"), 1'b0, 0);
    drain();
    check("p9_len", 32'(cap_q.size()), 32'd64);
    if (cap_q.size() == 64) begin
      zeros = 0;
      for (int i = 9; i < 60; i++) if (cap_q[i].data == 8'h00) zeros++;
      check("p9_pad_zeros", 32'(zeros), 32'd51);
      check("p9_last", 32'(cap_q[63].last), 32'd1);
      check("p9_last_early", 32'(cap_q[59].last), 32'd0);
    end

    // 60- and 61-byte payloads are never padded.
    for (int len = 60; len <= 61; len++) begin
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(8'(i));
      cap_q.delete();
      send_frame(fr, 1'b0, 0);
      drain();
      check("nopad_len", 32'(cap_q.size()), 32'(len + 4));
      if (cap_q.size() > 59) check("nopad_b59", 32'(cap_q[59].data), 32'h3B);
    end

    // Error flag on the tlast beat, then a clean frame.
    cap_q.delete();
    send_frame(str_bytes("123456789"), 1'b1, 0);
    drain();
    if (cap_q.size() == 64) begin
      check("err_user_last", 32'(cap_q[63].user), 32'd1);
      check("err_user_prev", 32'(cap_q[62].user), 32'd0);
    end else check("err_len", 32'(cap_q.size()), 32'd64);
    cap_q.delete();
    send_frame(str_bytes("123456789"), 1'b0, 0);
    drain();
    if (cap_q.size() == 64) check("after_err_user", 32'(cap_q[63].user), 32'd0);
    else check("after_err_len", 32'(cap_q.size()), 32'd64);

    // Random stalls, gaps and back-to-back frames on the padded instance.
    rand_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      fr.delete();
      for (int i = 0, l = $urandom_range(1, 80); i < l; i++) fr.push_back(8'($urandom_range(0, 255)));
      send_frame(fr, 1'($urandom_range(0, 3) == 0), 30);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of PAD, then a clean unpadded frame.
    send_frame(str_bytes("123456789"), 1'b0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tvalid", 32'(mo_tvalid), 32'd0);
    check("midrst_busy", 32'(mo_busy), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0;
    cap_q.delete();
    send_frame(str_bytes("123456789"), 1'b0, 0);
    drain();
    check("post_rst_len", 32'(cap_q.size()), 32'd13);
    if (cap_q.size() == 13) begin
      check("post_rst_fcs", {24'd0, cap_q[9].data} << 24 | {24'd0, cap_q[10].data} << 16 |
                            {24'd0, cap_q[11].data} << 8 | {24'd0, cap_q[12].data}, 32'h2639F4CB);
      check("post_rst_last", 32'(cap_q[12].last), 32'd1);
    end

    repeat (2) @(posedge clk);
    finish_run();
  end

endmodule
